seg7_scan_decoder: RTL and testbench

//  Receive side of the multiplexed 7-segment display bus (digit strobe + segment pattern).

---
 rtl/seg7_scan_decoder_if.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Bus between a 7-segment scan source (digit strobe + segment pattern) and the decoder.
// valid and err are single-cycle pulses with no ready/backpressure; a consumer must sample every cycle.
interface seg7_scan_decoder_if;
  logic [7:0] digit;
  logic [7:0] seg;
  logic [7:0] value;
  logic       valid;
  logic       err;
  logic [1:0] err_code;
  logic [1:0] dbg_state;

  modport master (
    output digit, seg,
    input  value, valid, err, err_code, dbg_state
  );

  modport slave (
    input  digit, seg,
    output value, valid, err, err_code, dbg_state
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Rebuilds an 8-bit value from a scanned hundreds/tens/units 7-segment bus and flags bad frames.
// Optional: define SEG7_DP_CHECK_EN to treat a lit decimal point on an accepted digit as a bad pattern.
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic clk,
  input logic rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GOT_H = 2'd1, GOT_T = 2'd2} state_t;

  state_t      r_state;
  logic [7:0]  r_digit, r_seg;
  logic [15:0] r_prev_pair;
  logic [15:0] r_settled;
  logic        r_settled_vld;
  logic [SW-1:0] r_stable;
  logic [TW-1:0] r_tmo;
  logic        r_sync;
  logic [3:0]  r_h, r_t;
  logic [7:0]  r_value;
  logic        r_valid, r_err;
  logic [1:0]  r_err_code;

  logic [15:0] w_pair;
  logic        w_same, w_settle, w_blank, w_act;
  logic        w_digit_bad, w_pat_bad, w_dec_ok;
  logic [3:0]  w_dec;
  logic [9:0]  w_sum;

  assign w_pair  = {r_digit, r_seg};
  assign w_same  = (w_pair == r_prev_pair);
  // A pair settles once per stable run, and never twice in a row, so a short glitch
  // followed by the original pair does not produce a second acceptance.
  assign w_settle = w_same && (r_stable == SW'(SETTLE_CYCLES - 1)) &&
                    !(r_settled_vld && (r_settled == w_pair));
  assign w_blank  = (r_digit == 8'h00);
  assign w_digit_bad = !((r_digit == 8'h01) || (r_digit == 8'h02) || (r_digit == 8'h04));
  // After reset, wait for a hundreds digit so a frame cut by reset never reports.
  assign w_act    = w_settle && !w_blank && (r_sync || (r_digit == 8'h04));

  always_comb begin
    w_dec_ok = 1'b1;
    w_dec    = 4'd0;
    case (r_seg[6:0])
      7'h3F: w_dec = 4'd0;
      7'h06: w_dec = 4'd1;
      7'h5B: w_dec = 4'd2;
      7'h4F: w_dec = 4'd3;
      7'h66: w_dec = 4'd4;
      7'h6D: w_dec = 4'd5;
      7'h7D: w_dec = 4'd6;
      7'h27: w_dec = 4'd7;
      7'h7F: w_dec = 4'd8;
      7'h6F: w_dec = 4'd9;
      default: w_dec_ok = 1'b0;
    endcase
  end

`ifdef SEG7_DP_CHECK_EN
  assign w_pat_bad = !w_dec_ok || r_seg[7];
`else
  assign w_pat_bad = !w_dec_ok;
`endif

  assign w_sum = ({6'd0, r_h} * 10'd100) + ({6'd0, r_t} * 10'd10) + {6'd0, w_dec};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_digit       <= 8'h00;
      r_seg         <= 8'h00;
      r_prev_pair   <= 16'h0000;
      r_settled     <= 16'h0000;
      r_settled_vld <= 1'b0;
      r_stable      <= '0;
      r_tmo         <= '0;
      r_sync        <= 1'b0;
      r_h           <= 4'd0;
      r_t           <= 4'd0;
      r_value       <= 8'h00;
      r_valid       <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 2'd0;
    end else begin
      r_digit     <= bus.digit;
      r_seg       <= bus.seg;
      r_prev_pair <= w_pair;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;

      if (!w_same)
        r_stable <= '0;
      else if (r_stable != SW'(SETTLE_CYCLES))
        r_stable <= r_stable + 1'b1;

      if (w_settle) begin
        r_settled     <= w_pair;
        r_settled_vld <= 1'b1;
      end

      if (w_act) begin
        r_sync <= 1'b1;
        r_tmo  <= '0;
        if (w_digit_bad) begin
          r_err <= 1'b1; r_err_code <= 2'd1; r_state <= IDLE;
        end else if (w_pat_bad) begin
          r_err <= 1'b1; r_err_code <= 2'd0; r_state <= IDLE;
        end else if (r_digit == 8'h04) begin
          r_h <= w_dec; r_state <= GOT_H;
        end else if (r_digit == 8'h02) begin
          if (r_state == GOT_H) begin
            r_t <= w_dec; r_state <= GOT_T;
          end else begin
            r_err <= 1'b1; r_err_code <= 2'd1; r_state <= IDLE;
          end
        end else begin
          r_state <= IDLE;
          if (r_state != GOT_T) begin
            r_err <= 1'b1; r_err_code <= 2'd1;
          end else if (w_sum <= 10'd255) begin
            r_value <= w_sum[7:0]; r_valid <= 1'b1;
          end else begin
            r_err <= 1'b1; r_err_code <= 2'd2;
          end
        end
      end else if (r_state != IDLE) begin
        if (r_tmo == TW'(TIMEOUT_CYCLES)) begin
          r_err <= 1'b1; r_err_code <= 2'd3; r_state <= IDLE; r_tmo <= '0;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign bus.value     = r_value;
  assign bus.valid     = r_valid;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder; a negedge monitor counts valid/err pulses and scores values.
module tb_seg7_scan_decoder;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_valid;
  int   n_err;
  int   n_both;
  logic [7:0] exp_q[$];

  seg7_scan_decoder_if bus ();

  seg7_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(200)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor + scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (bus.valid) begin
        n_valid = n_valid + 1;
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_valid value=%0d (no value expected)", bus.value);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.value !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL valid_value got=%0d exp=%0d", bus.value, e);
          end
        end
      end
      if (bus.err) n_err = n_err + 1;
      if (bus.valid && bus.err) n_both = n_both + 1;
    end
  end

  // driver
  task automatic drive(input logic [7:0] d, input logic [7:0] s, input int n);
    bus.digit = d;
    bus.seg   = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] h, input logic [7:0] t, input logic [7:0] u);
    drive(8'h04, h, 10); drive(8'h00, 8'h00, 10);
    drive(8'h02, t, 10); drive(8'h00, 8'h00, 10);
    drive(8'h01, u, 10); drive(8'h00, 8'h00, 10);
  endtask

  task automatic check_counts(input string name, input int v0, input int e0, input int dv, input int de);
    n_checks = n_checks + 1;
    if ((n_valid - v0) !== dv || (n_err - e0) !== de) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_pulses valid=%0d err=%0d exp valid=%0d err=%0d", name, n_valid - v0, n_err - e0, dv, de);
    end
  endtask

  task automatic check_code(input string name, input logic [1:0] c);
    n_checks = n_checks + 1;
    if (bus.err_code !== c) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_code got=%0d exp=%0d", name, bus.err_code, c);
    end
  endtask

  task automatic check_value(input string name, input logic [7:0] v);
    n_checks = n_checks + 1;
    if (bus.value !== v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_value got=%0d exp=%0d", name, bus.value, v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(8'h00, 8'h00, 3);
    n_checks = n_checks + 1;
    if (bus.value !== 8'd0 || bus.valid !== 1'b0 || bus.err !== 1'b0 || bus.err_code !== 2'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outputs value=%0d valid=%b err=%b code=%0d exp 0/0/0/0",
               bus.value, bus.valid, bus.err, bus.err_code);
    end
    rst = 1'b1;
    drive(8'h00, 8'h00, 10);
  endtask

  task automatic test_basic();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(8'd123);
    frame(8'h06, 8'h5B, 8'h4F);
    check_counts("basic", v0, e0, 1, 0);
    check_value("basic", 8'd123);
  endtask

  task automatic test_range();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    frame(8'h5B, 8'h6D, 8'h7D);
    check_counts("range", v0, e0, 0, 1);
    check_code("range", 2'd2);
    check_value("range_hold", 8'd123);
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(8'd123);
    drive(8'h04, 8'h06, 10); drive(8'h00, 8'h00, 10);
    drive(8'h02, 8'h5B, 8);
    drive(8'h02, 8'h5A, 3);
    drive(8'h02, 8'h5B, 8);
    drive(8'h00, 8'h00, 10);
    drive(8'h01, 8'h4F, 10); drive(8'h00, 8'h00, 10);
    check_counts("glitch", v0, e0, 1, 0);
    check_value("glitch", 8'd123);
  endtask

  task automatic test_order();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    drive(8'h04, 8'h3F, 10); drive(8'h00, 8'h00, 10);
    drive(8'h01, 8'h4F, 10); drive(8'h00, 8'h00, 10);
    check_counts("order", v0, e0, 0, 1);
    check_code("order", 2'd1);
    v0 = n_valid; e0 = n_err;
    exp_q.push_back(8'd42);
    frame(8'h3F, 8'h66, 8'h5B);
    check_counts("after_order", v0, e0, 1, 0);
    check_value("after_order", 8'd42);
  endtask

  task automatic test_timeout();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    drive(8'h04, 8'h06, 10);
    drive(8'h00, 8'h00, 250);
    check_counts("timeout", v0, e0, 0, 1);
    check_code("timeout", 2'd3);
  endtask

  task automatic test_bad_digit();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    drive(8'h08, 8'h06, 10); drive(8'h00, 8'h00, 10);
    check_counts("bad_digit", v0, e0, 0, 1);
    check_code("bad_digit", 2'd1);
  endtask

  task automatic test_bad_pattern();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    drive(8'h04, 8'h12, 10); drive(8'h00, 8'h00, 10);
    check_counts("bad_pattern", v0, e0, 0, 1);
    check_code("bad_pattern", 2'd0);
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    drive(8'h04, 8'h06, 10); drive(8'h00, 8'h00, 10);
    drive(8'h02, 8'h5B, 10); drive(8'h00, 8'h00, 10);
    rst = 1'b0;
    drive(8'h00, 8'h00, 1);
    rst = 1'b1;
    drive(8'h01, 8'h4F, 10); drive(8'h00, 8'h00, 10);
    check_counts("reset_mid", v0, e0, 0, 0);
    check_value("reset_mid", 8'd0);
  endtask

  task automatic test_dp();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    drive(8'h04, 8'hBF, 10); drive(8'h00, 8'h00, 10);
`ifdef SEG7_DP_CHECK_EN
    check_counts("dp_on", v0, e0, 0, 1);
    check_code("dp_on", 2'd0);
`else
    n_checks = n_checks + 1;
    if (bus.dbg_state !== 2'd1) begin
      n_fail = n_fail + 1;
      $display("FAIL dp_off_state got=%0d exp=1", bus.dbg_state);
    end
    exp_q.push_back(8'd12);
    drive(8'h02, 8'h06, 10); drive(8'h00, 8'h00, 10);
    drive(8'h01, 8'h5B, 10); drive(8'h00, 8'h00, 10);
    check_counts("dp_off", v0, e0, 1, 0);
    check_value("dp_off", 8'd12);
`endif
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_valid = 0; n_err = 0; n_both = 0;
    rst = 1'b0;
    bus.digit = 8'h00;
    bus.seg   = 8'h00;
    test_reset();
    test_basic();
    test_range();
    test_glitch();
    test_order();
    test_timeout();
    test_bad_digit();
    test_bad_pattern();
    test_reset_mid_frame();
    test_dp();
    n_checks = n_checks + 1;
    if (n_both !== 0) begin
      n_fail = n_fail + 1;
      $display("FAIL valid_err_overlap cycles=%0d exp=0", n_both);
    end
    n_checks = n_checks + 1;
    if (exp_q.size() !== 0) begin
      n_fail = n_fail + 1;
      $display("FAIL missing_valid pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
